mole_round_scheduler: RTL

MOLE_ROUND_SCHEDULER -- requirements
Module: mole_round_scheduler

---
 rtl/mole_round_scheduler.sv | 236 +++++++++++++++++++++++
 1 files changed

// File: rtl/mole_round_scheduler.sv
// mole_round_scheduler
// Round scheduler for a whack-a-mole game. Alternates between a GAP wait and
// an UP window for each mole, counts hits and misses, and ends the game on
// MAX_MISS misses or when time_up is raised.
//
// Optional feature macro: SPEEDUP_EN
//   When defined, each mole's UP time shrinks by 4 ticks for every 8 hits
//   scored so far, with a floor of 4 ticks.
//
// Parameters
//   LIFE_TICKS  ticks a mole stays up (1..255)
//   GAP_TICKS   ticks between moles (1..255)
//   MAX_MISS    misses that end the game (1..15)
//
// Ports
//   clk           system clock, rising edge
//   reset         asynchronous active-low reset
//   tick          one-clk timing enable; timers advance only on tick
//   start         active-low start button, asynchronous to clk
//   time_up       level, game time expired
//   hit           one-clk pulse when the current mole is struck
//   rand_row/col  random position sampled at spawn
//   is_started    high in GAP or UP
//   mole_visible  high in UP
//   mole_row/col  position latched at spawn
//   hit_cnt       hits this game (saturating)
//   miss_cnt      misses this game
//   game_over     high in OVER
//   spawn         one-clk pulse on each GAP->UP transition
module mole_round_scheduler #(
    parameter int unsigned LIFE_TICKS = 40,
    parameter int unsigned GAP_TICKS  = 10,
    parameter int unsigned MAX_MISS   = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       start,
    input  logic       time_up,
    input  logic       hit,
    input  logic [1:0] rand_row,
    input  logic [1:0] rand_col,
    output logic       is_started,
    output logic       mole_visible,
    output logic [1:0] mole_row,
    output logic [1:0] mole_col,
    output logic [9:0] hit_cnt,
    output logic [3:0] miss_cnt,
    output logic       game_over,
    output logic       spawn
);

    localparam int unsigned TIMER_W = 8;
    localparam int unsigned HIT_W   = 10;
    localparam int unsigned MISS_W  = 4;
    localparam int unsigned POS_W   = 2;

    localparam logic [TIMER_W-1:0] GAP_LOAD = TIMER_W'(GAP_TICKS);
    localparam logic [HIT_W-1:0]   HIT_MAX  = '1;
    localparam logic [MISS_W-1:0]  MISS_END = MISS_W'(MAX_MISS);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_GAP  = 2'd1,
        S_UP   = 2'd2,
        S_OVER = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [TIMER_W-1:0] r_timer;
    logic [TIMER_W-1:0] w_timer_nxt;
    logic [HIT_W-1:0]   r_hit_cnt;
    logic [HIT_W-1:0]   w_hit_nxt;
    logic [MISS_W-1:0]  r_miss_cnt;
    logic [MISS_W-1:0]  w_miss_nxt;
    logic [MISS_W-1:0]  w_miss_inc;
    logic [POS_W-1:0]   r_mole_row;
    logic [POS_W-1:0]   w_row_nxt;
    logic [POS_W-1:0]   r_mole_col;
    logic [POS_W-1:0]   w_col_nxt;
    logic               r_spawn;
    logic               w_spawn_nxt;
    logic               r_is_started;
    logic               r_mole_visible;
    logic               r_game_over;

    logic               r_start_meta;
    logic               r_start_sync;
    logic               r_start_prev;
    logic               w_start_evt;

    logic [TIMER_W-1:0] w_life_load;
    logic               w_timer_last;

    // Start button synchroniser plus one delay flop for falling-edge detect
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_start_meta <= 1'b1;
            r_start_sync <= 1'b1;
            r_start_prev <= 1'b1;
        end else begin
            r_start_meta <= start;
            r_start_sync <= r_start_meta;
            r_start_prev <= r_start_sync;
        end
    end

    assign w_start_evt = r_start_prev & ~r_start_sync;

`ifdef SPEEDUP_EN
    // 4*(hit_cnt/8) is hit_cnt[9:3] shifted up by two
    logic [HIT_W-1:0] w_cut;
    assign w_cut = {1'b0, r_hit_cnt[HIT_W-1:3], 2'b00};

    if (LIFE_TICKS >= 4) begin : g_floor
        always_comb begin
            w_life_load = TIMER_W'(4);
            if (HIT_W'(LIFE_TICKS) >= (w_cut + HIT_W'(4))) begin
                w_life_load = TIMER_W'(HIT_W'(LIFE_TICKS) - w_cut);
            end
        end
    end else begin : g_no_floor
        assign w_life_load = TIMER_W'(LIFE_TICKS);
    end
`else
    assign w_life_load = TIMER_W'(LIFE_TICKS);
`endif

    assign w_timer_last = (r_timer == TIMER_W'(1));
    assign w_miss_inc   = r_miss_cnt + MISS_W'(1);

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and datapath update; time_up beats hit, hit beats expiry
    always_comb begin
        w_state_nxt = r_state;
        w_timer_nxt = r_timer;
        w_hit_nxt   = r_hit_cnt;
        w_miss_nxt  = r_miss_cnt;
        w_row_nxt   = r_mole_row;
        w_col_nxt   = r_mole_col;
        w_spawn_nxt = 1'b0;

        case (r_state)
            S_IDLE, S_OVER: begin
                if (w_start_evt) begin
                    w_hit_nxt   = '0;
                    w_miss_nxt  = '0;
                    w_timer_nxt = GAP_LOAD;
                    w_state_nxt = S_GAP;
                end
            end
            S_GAP: begin
                if (time_up) begin
                    w_state_nxt = S_OVER;
                end else if (tick) begin
                    if (w_timer_last) begin
                        w_row_nxt   = rand_row;
                        w_col_nxt   = rand_col;
                        w_timer_nxt = w_life_load;
                        w_spawn_nxt = 1'b1;
                        w_state_nxt = S_UP;
                    end else begin
                        w_timer_nxt = r_timer - TIMER_W'(1);
                    end
                end
            end
            S_UP: begin
                if (time_up) begin
                    w_state_nxt = S_OVER;
                end else if (hit) begin
                    if (r_hit_cnt != HIT_MAX) begin
                        w_hit_nxt = r_hit_cnt + HIT_W'(1);
                    end
                    w_timer_nxt = GAP_LOAD;
                    w_state_nxt = S_GAP;
                end else if (tick) begin
                    if (w_timer_last) begin
                        w_miss_nxt  = w_miss_inc;
                        w_timer_nxt = GAP_LOAD;
                        w_state_nxt = (w_miss_inc == MISS_END) ? S_OVER : S_GAP;
                    end else begin
                        w_timer_nxt = r_timer - TIMER_W'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Datapath and registered status outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_timer        <= '0;
            r_hit_cnt      <= '0;
            r_miss_cnt     <= '0;
            r_mole_row     <= '0;
            r_mole_col     <= '0;
            r_spawn        <= 1'b0;
            r_is_started   <= 1'b0;
            r_mole_visible <= 1'b0;
            r_game_over    <= 1'b0;
        end else begin
            r_timer        <= w_timer_nxt;
            r_hit_cnt      <= w_hit_nxt;
            r_miss_cnt     <= w_miss_nxt;
            r_mole_row     <= w_row_nxt;
            r_mole_col     <= w_col_nxt;
            r_spawn        <= w_spawn_nxt;
            r_is_started   <= (w_state_nxt == S_GAP) || (w_state_nxt == S_UP);
            r_mole_visible <= (w_state_nxt == S_UP);
            r_game_over    <= (w_state_nxt == S_OVER);
        end
    end

    assign is_started   = r_is_started;
    assign mole_visible = r_mole_visible;
    assign mole_row     = r_mole_row;
    assign mole_col     = r_mole_col;
    assign hit_cnt      = r_hit_cnt;
    assign miss_cnt     = r_miss_cnt;
    assign game_over    = r_game_over;
    assign spawn        = r_spawn;

endmodule
